// File: rtl/apb2_pkg.sv
// Shared APB2 definitions: requester state encoding, default pprot value
// and the register offsets used by the completers on this bus.
package apb2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb2_req_state_t;

    localparam logic [2:0] APB2_PROT_DEFAULT = 3'b000;

    localparam logic [7:0] APB2_REG_STATUS   = 8'h00;
    localparam logic [7:0] APB2_REG_COUNTER  = 8'h04;
    localparam logic [7:0] APB2_REG_ROT_DUR  = 8'h08;
    localparam logic [7:0] APB2_REG_RPM      = 8'h0C;
    localparam logic [7:0] APB2_REG_CONTROL  = 8'h10;
    localparam logic [7:0] APB2_REG_PWM_CTRL = 8'h14;

endpackage

// File: rtl/apb2_timeout_counter.sv
// ACCESS-phase wait counter for the APB2 requester.
// Ports: pclk, preset_n, clear, count_en in; terminal out (count == limit-1).
module apb2_timeout_counter #(
    parameter int unsigned limit = 256
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int unsigned cw = (limit > 1) ? $clog2(limit) : 1;

    logic [cw-1:0] count;

    // Saturates at the terminal value so a late abort never wraps.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !terminal) begin
            count <= count + cw'(1);
        end
    end

    assign terminal = (count == cw'(limit - 1));

endmodule

// File: rtl/apb2_requester.sv
// APB2 requester: one command (valid/ready) -> one SETUP/ACCESS transfer
// -> one response (valid/ready). Ports: pclk, preset_n, cmd_*, rsp_*, APB
// psel/penable/pwrite/paddr/pwdata/pstrb/pprot out, prdata/pready/pslverr in.
// Optional ACCESS timeout abort: define APB2_REQ_TIMEOUT_EN.
module apb2_requester
    import apb2_pkg::*;
#(
    parameter int unsigned data_width     = 32,
    parameter int unsigned addr_width     = 8,
    parameter int unsigned timeout_cycles = 256,
    parameter logic [2:0]  prot_value     = APB2_PROT_DEFAULT
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [data_width/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [addr_width-1:0]   paddr,
    output logic [data_width-1:0]   pwdata,
    output logic [data_width/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [data_width-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [addr_width-1:0] align_mask =
        addr_width'(data_width / 8 - 1);

    apb2_req_state_t state;

    logic misaligned;
    assign misaligned = |(cmd_addr & align_mask);

`ifdef APB2_REQ_TIMEOUT_EN
    logic tmo_hit;

    apb2_timeout_counter #(
        .limit(timeout_cycles)
    ) u_tmo (
        .pclk    (pclk),
        .preset_n(preset_n),
        .clear   (state == SETUP),
        .count_en((state == ACCESS) && !pready),
        .terminal(tmo_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^timeout_cycles;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= prot_value;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            pprot <= prot_value;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (misaligned) begin
                            // Rejected locally; the bus is never touched.
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state       <= RESP;
                        end else begin
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            pwrite  <= cmd_write;
                            paddr   <= cmd_addr;
                            pwdata  <= cmd_write ? cmd_wdata : '0;
                            pstrb   <= cmd_write ? cmd_strb : '0;
                            state   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= RESP;
                    end
`ifdef APB2_REQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb2_requester.md
Name: apb2_requester

Overview:
- APB2 bus requester (initiator) that turns a simple valid/ready command stream into single APB2 SETUP/ACCESS transfers.
- Returns the read data and error status on a valid/ready response stream.
- Sits between a control source (soft-core bridge, test sequencer, or autonomous supervisor) and APB2 completers such as the BLDC peripheral.
- Handles one transfer at a time; no outstanding requests.

Parameters:
- data_width, 32, APB data width in bits; multiple of 8.
- addr_width, 8, APB address width in bits.
- timeout_cycles, 256, maximum ACCESS cycles before abort; used only with the timeout feature.
- prot_value, 3'b000, constant driven on pprot.

Ports:
- pclk  in  1  bus clock.
- preset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addr_width  byte address.
- cmd_wdata  in  data_width  write data.
- cmd_strb  in  data_width/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  data_width  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, misaligned address, or timeout.
- rsp_timeout  out  1  error cause was timeout.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  addr_width  APB address.
- pwdata  out  data_width  APB write data.
- pstrb  out  data_width/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  data_width  completer read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

Behaviour:
- All outputs are registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=prot_value, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0. State = IDLE.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, capture cmd_write/addr/wdata/strb and clear cmd_ready.
  - If cmd_addr[$clog2(data_width/8)-1:0] != 0, go to RESP with rsp_err=1, rsp_rdata=0. psel never asserts.
  - Otherwise go to SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the captured values.
- SETUP: unconditionally to ACCESS after one cycle; penable=1. pready sampled in SETUP is ignored.
- ACCESS:
  - Hold psel=1, penable=1 and all address/data stable while pready=0.
  - On an edge with pready=1:
    - capture rsp_err=pslverr;
    - capture rsp_rdata=prdata for reads, 0 for writes (also 0 when pslverr=1);
    - drive psel=0, penable=0, rsp_valid=1;
    - go to RESP.
- RESP:
  - Hold rsp_* stable until an edge with rsp_valid&rsp_ready.
  - Then rsp_valid=0, cmd_ready=1, state IDLE.
  - rsp_ready may already be high when rsp_valid rises; rsp_valid is still visible for at least one cycle.
- Latency with a zero-wait completer:
  - accept edge N: psel high after N;
  - penable high after N+1;
  - rsp_valid high after N+2.
  - The next command is accepted no earlier than the edge after the response handshake.
- pwdata and pstrb are driven to 0 for reads.
- Async reset mid-transfer: all outputs return to reset values immediately. The transfer is dropped and no response is issued.

Optional Feature:
- Macro: APB2_REQ_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches timeout_cycles-1 with pready still 0: drive psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
  - If pready=1 on that same edge, normal completion wins.
- Not defined: ACCESS waits indefinitely; rsp_timeout is tied 0; the counter is absent; timeout_cycles is unused.

Decomposition:
- Shared package apb2_pkg:
  - apb2_req_state_t enum (IDLE, SETUP, ACCESS, RESP);
  - APB2_PROT_DEFAULT constant;
  - register offset constants shared with completers (status 0x00, counter 0x04, rotation duration 0x08, rpm 0x0C, control 0x10, pwm control 0x14).
- One sub-module: apb2_timeout_counter (clear, count-enable, terminal-count output), instantiated only under APB2_REQ_TIMEOUT_EN.

Test Plan:
- Write 0x10 data 0x00000003 to the BLDC peripheral, then read 0x10 → psel/penable sequence correct, write response rsp_err=0, rdata=0; read response rsp_rdata=0x00000003.
- Completer model holds pready=0 for 5 ACCESS cycles, read 0x0C returning 0x00000BB8 → paddr/psel/penable stable for all 6 ACCESS cycles; rsp_rdata=0x00000BB8 one edge after pready.
- cmd_addr=0x06 → psel never asserts; rsp_valid after 1 cycle, rsp_err=1, rsp_rdata=0.
- pslverr=1 with pready=1 on a read of 0x20 → rsp_err=1, rsp_rdata=0, rsp_timeout=0.
- APB2_REQ_TIMEOUT_EN, timeout_cycles=16, pready stuck 0 → abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; next command accepted normally.
- Assert preset_n=0 mid-ACCESS with rsp_ready held low → psel/penable/rsp_valid drop immediately, cmd_ready=1 after release, no stale response appears.
